// File: rtl/ir_pkg.sv
// ir_pkg -- shared definitions for the NEC infrared decoder.
//   ir_state_e        : decoder FSM state encoding
//   NEC_* constants   : default NEC timing windows in 1 us ticks
//   inv_ok()          : address/command complement check on a received frame
package ir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_REP_MARK
  } ir_state_e;

  localparam logic [15:0] NEC_LEAD_MARK_MIN  = 16'd8500;
  localparam logic [15:0] NEC_LEAD_MARK_MAX  = 16'd9500;
  localparam logic [15:0] NEC_LEAD_SPACE_MIN = 16'd4000;
  localparam logic [15:0] NEC_REP_SPACE_MIN  = 16'd2000;
  localparam logic [15:0] NEC_REP_SPACE_MAX  = 16'd2500;
  localparam logic [15:0] NEC_BIT_MARK_MIN   = 16'd400;
  localparam logic [15:0] NEC_BIT_MARK_MAX   = 16'd700;
  localparam logic [15:0] NEC_BIT1_SPACE_MIN = 16'd1000;
  localparam logic [15:0] NEC_TIMEOUT        = 16'd12000;

  // Last bit index of a 32-bit frame; reaching it ends the data phase.
  localparam logic [5:0]  NEC_LAST_BIT       = 6'd31;

  // The low byte pair of a frame carries a command and its complement.
  function automatic logic inv_ok(input logic [31:0] frame);
    return frame[15:8] == ~frame[7:0];
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// ir_tick_gen -- free-running divider producing a one-clk enable pulse.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : high for one clk every DIV clks (always high when DIV = 1)
module ir_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int          W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  // NOTE: state registers are written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder -- NEC infrared remote frame and repeat-code decoder.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   i_ir_rxb : raw IR receiver output, active-low, asynchronous
//   o_data   : last accepted frame, first received bit in [31]
//   o_valid  : one-clk pulse when o_data is updated
//   o_repeat : one-clk pulse on an accepted repeat code
//   o_err    : one-clk pulse on a rejected frame
//   o_busy   : high while a frame or repeat code is being received
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int          CLK_HZ         = 50000000,
  parameter int          TICK_US        = 1,
  parameter logic [15:0] LEAD_MARK_MIN  = NEC_LEAD_MARK_MIN,
  parameter logic [15:0] LEAD_MARK_MAX  = NEC_LEAD_MARK_MAX,
  parameter logic [15:0] LEAD_SPACE_MIN = NEC_LEAD_SPACE_MIN,
  parameter logic [15:0] REP_SPACE_MIN  = NEC_REP_SPACE_MIN,
  parameter logic [15:0] REP_SPACE_MAX  = NEC_REP_SPACE_MAX,
  parameter logic [15:0] BIT_MARK_MIN   = NEC_BIT_MARK_MIN,
  parameter logic [15:0] BIT_MARK_MAX   = NEC_BIT_MARK_MAX,
  parameter logic [15:0] BIT1_SPACE_MIN = NEC_BIT1_SPACE_MIN,
  parameter logic [15:0] TIMEOUT        = NEC_TIMEOUT,
  parameter bit          CHECK_INV      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ir_rxb,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_repeat,
  output logic        o_err,
  output logic        o_busy
);

  localparam int DIV = int'((longint'(CLK_HZ) * longint'(TICK_US)) / longint'(1000000));

  logic        tick;
  logic [1:0]  sync_q;
  logic        ir, ir_q, ir_rise, ir_fall;
  logic [15:0] dur_q;

  ir_state_e   state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        have_q, have_d;
  logic        valid_q, valid_d, rep_q, rep_d, err_q, err_d;
  logic        bit_mark_ok, timeout, frame_ok;

  ir_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Inversion happens at the synchroniser input so that cleared flops mean
  // "no mark"; the flops carry the active-high ir level.
  assign ir      = sync_q[1];
  assign ir_rise = ir & ~ir_q;
  assign ir_fall = ~ir & ir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      ir_q   <= 1'b0;
      dur_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], ~i_ir_rxb};
      ir_q   <= ir;
      // Each mark or space is timed from its own starting edge.
      if (ir_rise || ir_fall) begin
        dur_q <= '0;
      end else if (tick && dur_q != 16'hFFFF) begin
        dur_q <= dur_q + 16'd1;
      end
    end
  end

  assign bit_mark_ok = (dur_q >= BIT_MARK_MIN) && (dur_q <= BIT_MARK_MAX);
  assign timeout     = (dur_q >= TIMEOUT);
  assign frame_ok    = !CHECK_INV || inv_ok(shift_q);

  // NOTE: every variable driven here receives a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    have_d    = have_q;
    valid_d   = 1'b0;
    rep_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ir_rise) state_d = S_LEAD_MARK;
      end
      S_LEAD_MARK: begin
        if (ir_fall) begin
          if (dur_q >= LEAD_MARK_MIN && dur_q <= LEAD_MARK_MAX) state_d = S_LEAD_SPACE;
          else err_d = 1'b1;
        end
      end
      S_LEAD_SPACE: begin
        if (ir_rise) begin
          if (dur_q >= LEAD_SPACE_MIN) begin
            state_d   = S_BIT_MARK;
            bit_cnt_d = '0;
          end else if (dur_q >= REP_SPACE_MIN && dur_q <= REP_SPACE_MAX) begin
            state_d = S_REP_MARK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_BIT_MARK: begin
        if (ir_fall) begin
          if (bit_mark_ok) state_d = S_BIT_SPACE;
          else err_d = 1'b1;
        end
      end
      S_BIT_SPACE: begin
        if (ir_rise) begin
          shift_d   = {shift_q[30:0], (dur_q >= BIT1_SPACE_MIN)};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == NEC_LAST_BIT) ? S_STOP_MARK : S_BIT_MARK;
        end
      end
      S_STOP_MARK: begin
        if (ir_fall) begin
          if (bit_mark_ok && frame_ok) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            have_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REP_MARK: begin
        if (ir_fall) begin
          if (bit_mark_ok) begin
            // A repeat with no earlier frame has nothing to repeat.
            rep_d   = have_q;
            state_d = S_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An edge restarts the counter, so a timeout only applies between edges.
    if (state_q != S_IDLE && timeout && !ir_rise && !ir_fall) err_d = 1'b1;
    if (err_d) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      have_q    <= 1'b0;
      valid_q   <= 1'b0;
      rep_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      have_q    <= have_d;
      valid_q   <= valid_d;
      rep_q     <= rep_d;
      err_q     <= err_d;
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_repeat = rep_q;
  assign o_err    = err_q;
  assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder -- self-checking bench for ir_nec_decoder.
// Two instances share the IR line: index 0 checks the command complement,
// index 1 does not. The clock is 100 kHz with a 20 us tick (divider of 2),
// and every timing window is the NEC default scaled to 20 us ticks.
`timescale 1us/1ns
module tb_ir_nec_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxb = 1'b1;

  always #5 clk = ~clk;

  logic [31:0] data_w  [2];
  logic        valid_w [2];
  logic        rep_w   [2];
  logic        err_w   [2];
  logic        busy_w  [2];

  ir_nec_decoder #(
    .CLK_HZ(100000), .TICK_US(20),
    .LEAD_MARK_MIN(16'd425), .LEAD_MARK_MAX(16'd475), .LEAD_SPACE_MIN(16'd200),
    .REP_SPACE_MIN(16'd100), .REP_SPACE_MAX(16'd125),
    .BIT_MARK_MIN(16'd20), .BIT_MARK_MAX(16'd35), .BIT1_SPACE_MIN(16'd50),
    .TIMEOUT(16'd600), .CHECK_INV(1'b1)
  ) dut_inv (
    .clk(clk), .rst(rst), .i_ir_rxb(rxb),
    .o_data(data_w[0]), .o_valid(valid_w[0]), .o_repeat(rep_w[0]),
    .o_err(err_w[0]), .o_busy(busy_w[0])
  );

  ir_nec_decoder #(
    .CLK_HZ(100000), .TICK_US(20),
    .LEAD_MARK_MIN(16'd425), .LEAD_MARK_MAX(16'd475), .LEAD_SPACE_MIN(16'd200),
    .REP_SPACE_MIN(16'd100), .REP_SPACE_MAX(16'd125),
    .BIT_MARK_MIN(16'd20), .BIT_MARK_MAX(16'd35), .BIT1_SPACE_MIN(16'd50),
    .TIMEOUT(16'd600), .CHECK_INV(1'b0)
  ) dut_noinv (
    .clk(clk), .rst(rst), .i_ir_rxb(rxb),
    .o_data(data_w[1]), .o_valid(valid_w[1]), .o_repeat(rep_w[1]),
    .o_err(err_w[1]), .o_busy(busy_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses and flags overlapping or stretched pulses.
  int   c_valid [2] = '{0, 0};
  int   c_rep   [2] = '{0, 0};
  int   c_err   [2] = '{0, 0};
  int   c_viol      = 0;
  logic p_valid [2] = '{1'b0, 1'b0};
  logic p_rep   [2] = '{1'b0, 1'b0};
  logic p_err   [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (valid_w[k]) c_valid[k]++;
      if (rep_w[k])   c_rep[k]++;
      if (err_w[k])   c_err[k]++;
      if ((int'(valid_w[k]) + int'(rep_w[k]) + int'(err_w[k])) > 1) c_viol++;
      if ((valid_w[k] && p_valid[k]) || (rep_w[k] && p_rep[k]) || (err_w[k] && p_err[k])) c_viol++;
      p_valid[k] = valid_w[k];
      p_rep[k]   = rep_w[k];
      p_err[k]   = err_w[k];
    end
  end

  // Reference model: outcome of whole transactions, per instance.
  logic [31:0] m_data  [2] = '{32'h0, 32'h0};
  bit          m_have  [2] = '{1'b0, 1'b0};
  int          e_valid [2], e_rep [2], e_err [2];
  int          b_valid [2], b_rep [2], b_err [2];

  task automatic model_frame(input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      if (k == 1 || d[15:8] == ~d[7:0]) begin
        m_data[k] = d;
        m_have[k] = 1'b1;
        e_valid[k]++;
      end else begin
        e_err[k]++;
      end
    end
  endtask

  task automatic model_repeat();
    for (int k = 0; k < 2; k++) if (m_have[k]) e_rep[k]++;
  endtask

  task automatic model_error();
    for (int k = 0; k < 2; k++) e_err[k]++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_data[k] = 32'h0;
      m_have[k] = 1'b0;
    end
  endtask

  task automatic begin_scn();
    for (int k = 0; k < 2; k++) begin
      b_valid[k] = c_valid[k];
      b_rep[k]   = c_rep[k];
      b_err[k]   = c_err[k];
      e_valid[k] = 0;
      e_rep[k]   = 0;
      e_err[k]   = 0;
    end
  endtask

  task automatic end_scn(input string tag);
    rxb = 1'b1;
    #2000;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/i%0d valid_cnt", tag, k), 32'(c_valid[k] - b_valid[k]), 32'(e_valid[k]));
      check($sformatf("%s/i%0d repeat_cnt", tag, k), 32'(c_rep[k] - b_rep[k]), 32'(e_rep[k]));
      check($sformatf("%s/i%0d err_cnt", tag, k), 32'(c_err[k] - b_err[k]), 32'(e_err[k]));
      check($sformatf("%s/i%0d data", tag, k), data_w[k], m_data[k]);
      check($sformatf("%s/i%0d busy", tag, k), 32'(busy_w[k]), 32'd0);
    end
  endtask

  // IR line driver; durations in microseconds, optional +/-40 us jitter.
  bit jit_on = 1'b0;

  function automatic int jit();
    return jit_on ? (int'($urandom_range(0, 80)) - 40) : 0;
  endfunction

  task automatic mark(input int us);
    rxb = 1'b0;
    #(us);
  endtask

  task automatic space(input int us);
    rxb = 1'b1;
    #(us);
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits);
    mark(9000 + jit());
    space(4500 + jit());
    for (int i = 0; i < nbits; i++) begin
      mark(560 + jit());
      space((d[31 - i] ? 1690 : 560) + jit());
    end
  endtask

  task automatic send_frame(input logic [31:0] d);
    send_bits(d, 32);
    mark(560 + jit());
    rxb = 1'b1;
  endtask

  task automatic send_repeat();
    mark(9000 + jit());
    space(2250 + jit());
    mark(560 + jit());
    rxb = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/i%0d data", tag, k), data_w[k], 32'h0);
      check($sformatf("%s/i%0d pulses", tag, k),
            {29'h0, valid_w[k], rep_w[k], err_w[k]}, 32'h0);
      check($sformatf("%s/i%0d busy", tag, k), 32'(busy_w[k]), 32'd0);
    end
  endtask

  logic [31:0] rnd;

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Repeat code with no stored frame is ignored silently.
    begin_scn();
    send_repeat();
    model_repeat();
    end_scn("rep_after_reset");

    // Reference frame, then a repeat code.
    begin_scn();
    send_frame(32'h00FF30CF);
    model_frame(32'h00FF30CF);
    end_scn("frame_30CF");

    begin_scn();
    send_repeat();
    model_repeat();
    end_scn("repeat");

    // Broken complement: rejected only where the check is enabled.
    begin_scn();
    send_frame(32'h00FF30CE);
    model_frame(32'h00FF30CE);
    end_scn("frame_30CE");

    // Leader mark too short.
    begin_scn();
    mark(6000);
    rxb = 1'b1;
    model_error();
    end_scn("short_leader");

    // Mark stuck after a valid leader: timeout, busy while waiting.
    begin_scn();
    mark(9000);
    space(4500);
    mark(5000);
    for (int k = 0; k < 2; k++)
      check($sformatf("timeout/i%0d busy_mid", k), 32'(busy_w[k]), 32'd1);
    mark(10000);
    rxb = 1'b1;
    model_error();
    end_scn("timeout");

    // Reset after bit 16 discards the partial frame without an error.
    begin_scn();
    send_bits(32'h20DF10EF, 16);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    model_reset();
    end_scn("mid_reset");

    begin_scn();
    send_frame(32'h20DF10EF);
    model_frame(32'h20DF10EF);
    end_scn("after_reset_frame");

    // Randomised frames with timing jitter, sometimes followed by a repeat.
    jit_on = 1'b1;
    for (int n = 0; n < 3; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 1) == 1) rnd[15:8] = ~rnd[7:0];
      begin_scn();
      send_frame(rnd);
      model_frame(rnd);
      if ($urandom_range(0, 1) == 1) begin
        space(3000);
        send_repeat();
        model_repeat();
      end
      end_scn($sformatf("random%0d", n));
    end

    check("pulse_rules", 32'(c_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter TICK_US, default 1: timing-tick period in microseconds.
REQ-003 Parameter LEAD_MARK_MIN/MAX, default 8500/9500 ticks: accepted leader mark window.
REQ-004 Parameter LEAD_SPACE_MIN, default 4000 ticks: minimum data-frame leader space.
REQ-005 Parameter REP_SPACE_MIN/MAX, default 2000/2500 ticks: accepted repeat-code leader space window.
REQ-006 Parameter BIT_MARK_MIN/MAX, default 400/700 ticks: accepted bit mark window.
REQ-007 Parameter BIT1_SPACE_MIN, default 1000 ticks: a bit space at or above this value decodes as 1.
REQ-008 Parameter TIMEOUT, default 12000 ticks: abort limit for any single mark or space.
REQ-009 Parameter CHECK_INV, default 1: 1 = frame valid only if data[15:8] == ~data[7:0]; 0 = no check.
REQ-010 clk  input  1  system clock.
REQ-011 rst  input  1  reset, synchronous to clk, active-high.
REQ-012 i_ir_rxb  input  1  raw IR receiver output, active-low (mark = 0), asynchronous.
REQ-013 o_data  output  32  last valid frame; first received bit in [31].
REQ-014 o_valid  output  1  one-clk pulse when o_data is updated.
REQ-015 o_repeat  output  1  one-clk pulse on an accepted repeat code.
REQ-016 o_err  output  1  one-clk pulse on any rejected frame.
REQ-017 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 i_ir_rxb SHALL pass through a 2-flop synchroniser on clk and be inverted to form ir (mark = 1); edges are detected from the synchronised signal.
REQ-019 A tick enable SHALL pulse for one clk every CLK_HZ*TICK_US/1000000 clk cycles; no derived clocks.
REQ-020 A 16-bit duration counter SHALL clear on every ir edge, increment on each tick, and saturate at 65535.
REQ-021 FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK.
REQ-022 IDLE -> LEAD_MARK on an ir rising edge.
REQ-023 LEAD_MARK -> LEAD_SPACE on a falling edge if the count is within [LEAD_MARK_MIN, LEAD_MARK_MAX]; otherwise error.
REQ-024 LEAD_SPACE, on a rising edge: count >= LEAD_SPACE_MIN -> BIT_MARK with bit counter = 0; count within [REP_SPACE_MIN, REP_SPACE_MAX] -> REP_MARK; otherwise error.
REQ-025 BIT_MARK -> BIT_SPACE on a falling edge if the count is within [BIT_MARK_MIN, BIT_MARK_MAX]; otherwise error.
REQ-026 BIT_SPACE, on a rising edge: shift (count >= BIT1_SPACE_MIN) into the LSB of the 32-bit shift register and increment the bit counter; after bit 32 -> STOP_MARK, else -> BIT_MARK.
REQ-027 STOP_MARK, on a falling edge with a valid bit-mark count: if the check passes, load o_data, pulse o_valid, set the have_frame flag, then return to IDLE; otherwise error.
REQ-028 REP_MARK, on a falling edge with a valid bit-mark count: pulse o_repeat only if have_frame = 1 (o_data unchanged), then return to IDLE; if have_frame = 0, return silently.
REQ-029 Error SHALL pulse o_err for one clk, return to IDLE, and leave o_data and have_frame unchanged.
REQ-030 In any non-IDLE state, count >= TIMEOUT SHALL be treated as an error.
REQ-031 o_valid, o_repeat and o_err SHALL be mutually exclusive in any cycle.
REQ-032 Latency: o_valid asserts 1 clk after the synchronised stop-mark falling edge.

Reset
REQ-033 While rst = 1: FSM = IDLE, o_data = 0, o_valid/o_repeat/o_err/o_busy = 0, counters, synchroniser flops (ir = 0), shift register and have_frame cleared.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no o_err pulse.

Structure
REQ-035 Package ir_pkg SHALL hold the FSM state encoding and the default NEC timing constants.
REQ-036 The tick enable SHALL be a sub-module, ir_tick_gen (parameter DIV, outputs a 1-clk pulse).

Verification
REQ-037 NEC frame 0x00FF30CF (first bit = MSB), default timing -> one o_valid, o_data = 0x00FF30CF, no o_err.
REQ-038 Same frame, then a repeat code (9 ms mark / 2.25 ms space / 560 us mark) -> one o_repeat, o_data still 0x00FF30CF.
REQ-039 Repeat code immediately after reset -> no pulses; returns to IDLE.
REQ-040 Frame 0x00FF30CE with CHECK_INV = 1 -> o_err, o_data unchanged; with CHECK_INV = 0 -> o_valid, o_data = 0x00FF30CE.
REQ-041 Leader mark of 6 ms -> o_err; ir held at mark for 15 ms after the leader -> o_err on timeout; o_busy = 0 afterwards.
REQ-042 rst asserted after bit 16 of a frame -> all outputs 0, no o_err; the next complete frame decodes correctly.
